// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM encoding and saturation limits for the PE MAC stage
package pe_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MAC   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/pe_mac_unit.sv
// pe_mac_unit: signed multiply plus accumulate-add
// PE_MAC_SATURATE_EN compiles in clamping of the product and of the sum.
module pe_mac_unit import pe_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [PSUM_WIDTH-1:0] acc,
    output logic signed [PSUM_WIDTH-1:0] acc_next
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    assign prod = a * b;
`ifdef PE_MAC_SATURATE_EN
    longint                      pl;
    logic signed [PSUM_WIDTH-1:0] p;
    logic signed [PSUM_WIDTH:0]   sum;
    always_comb begin
        pl = longint'(prod);
        p = pl > sat_max(PSUM_WIDTH) ? PSUM_WIDTH'(sat_max(PSUM_WIDTH)) :
            pl < sat_min(PSUM_WIDTH) ? PSUM_WIDTH'(sat_min(PSUM_WIDTH)) : PSUM_WIDTH'(pl);
        sum = {acc[PSUM_WIDTH-1], acc} + {p[PSUM_WIDTH-1], p};
        // differing top two bits of the widened sum mean overflow; the top bit gives the direction
        acc_next = sum[PSUM_WIDTH] != sum[PSUM_WIDTH-1] ?
                   (sum[PSUM_WIDTH] ? PSUM_WIDTH'(sat_min(PSUM_WIDTH)) : PSUM_WIDTH'(sat_max(PSUM_WIDTH))) :
                   sum[PSUM_WIDTH-1:0];
    end
`else
    assign acc_next = acc + PSUM_WIDTH'(prod);
`endif
endmodule

// File: rtl/pe_mac_stage.sv
// pe_mac_stage: pops ifmap/filter pairs, accumulates filt_len products per psum, writes num_out psums
// PE_MAC_SATURATE_EN selects saturating accumulation in pe_mac_unit.
module pe_mac_stage import pe_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 16,
    parameter int LEN_WIDTH  = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  filt_len,
    input  logic [CNT_WIDTH-1:0]  num_out,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] ifmap_dout,
    input  logic                  ifmap_empty,
    output logic                  ifmap_ren,
    input  logic [DATA_WIDTH-1:0] filt_dout,
    input  logic                  filt_empty,
    output logic                  filt_ren,
    output logic [PSUM_WIDTH-1:0] psum_din,
    output logic                  psum_wen,
    input  logic                  psum_full
);
    logic [2:0]                   state;
    logic [LEN_WIDTH-1:0]         len, mac_cnt;
    logic [CNT_WIDTH-1:0]         num, out_cnt;
    logic signed [DATA_WIDTH-1:0] a, b;
    logic signed [PSUM_WIDTH-1:0] acc, acc_next;
    logic                         op_valid, pop, last_pop, wr, last_wr;

    assign pop       = state == ST_MAC && !ifmap_empty && !filt_empty;
    assign last_pop  = pop && mac_cnt == len - LEN_WIDTH'(1);
    assign wr        = state == ST_WRITE && !psum_full;
    assign last_wr   = wr && out_cnt == num - CNT_WIDTH'(1);
    assign ifmap_ren = pop;
    assign filt_ren  = pop;
    assign psum_wen  = wr;
    assign psum_din  = acc;
    assign busy      = state != ST_IDLE;
    assign done      = state == ST_DONE;

    pe_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH)) u_mac (
        .a(a), .b(b), .acc(acc), .acc_next(acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            num      <= '0;
            mac_cnt  <= '0;
            out_cnt  <= '0;
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            op_valid <= 1'b0;
        end else begin
            op_valid <= pop;
            if (pop) begin
                a <= ifmap_dout;
                b <= filt_dout;
            end
            // the last pair is accumulated in DRAIN, so op_valid never overlaps a clear below
            if (op_valid) acc <= acc_next;
            case (state)
                ST_IDLE: if (start) begin
                    len     <= filt_len;
                    num     <= num_out;
                    mac_cnt <= '0;
                    out_cnt <= '0;
                    acc     <= '0;
                    state   <= (filt_len == '0 || num_out == '0) ? ST_DONE : ST_MAC;
                end
                ST_MAC: if (pop) begin
                    mac_cnt <= last_pop ? '0 : mac_cnt + LEN_WIDTH'(1);
                    if (last_pop) state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_WRITE;
                ST_WRITE: if (wr) begin
                    out_cnt <= out_cnt + CNT_WIDTH'(1);
                    state   <= last_wr ? ST_DONE : ST_MAC;
                    if (!last_wr) acc <= '0;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_mac_stage.sv
// tb_pe_mac_stage: table-driven directed vectors plus reset-abort sequence for pe_mac_stage
module tb_pe_mac_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  filt_len = '0;
    logic [3:0]  num_out = '0;
    logic        busy, done;
    logic [7:0]  ifmap_dout, filt_dout;
    logic        ifmap_empty, filt_empty, ifmap_ren, filt_ren;
    logic [15:0] psum_din;
    logic        psum_wen;
    logic        psum_full = 1'b0;

    logic [7:0] iq [16];
    logic [7:0] fq [16];
    int ip = 0, fp = 0, ibase = 0, fbase = 0, icnt = 0, fcnt = 0;
    logic stall_e = 1'b0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifmap_ren) ip <= ip + 1;
        if (filt_ren)  fp <= fp + 1;
    end
    assign ifmap_dout  = iq[4'(ip - ibase)];
    assign filt_dout   = fq[4'(fp - fbase)];
    assign ifmap_empty = (ip - ibase) >= icnt || stall_e;
    assign filt_empty  = (fp - fbase) >= fcnt;

    pe_mac_stage dut (
        .clk(clk), .rst(rst), .start(start), .filt_len(filt_len), .num_out(num_out),
        .busy(busy), .done(done),
        .ifmap_dout(ifmap_dout), .ifmap_empty(ifmap_empty), .ifmap_ren(ifmap_ren),
        .filt_dout(filt_dout), .filt_empty(filt_empty), .filt_ren(filt_ren),
        .psum_din(psum_din), .psum_wen(psum_wen), .psum_full(psum_full)
    );

    // operands and expectations are packed with element 0 rightmost
    typedef struct {
        logic [3:0]       len;
        logic [3:0]       num;
        int               nops;
        logic [7:0][7:0]  ia;
        logic [7:0][7:0]  fa;
        logic [2:0][15:0] psum;
        logic [2:0][7:0]  wcyc;
        int               done_c;
        int               es, ee, fs, fe;
        bit               hold;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        ibase = ip;
        fbase = fp;
        for (int i = 0; i < 8; i++) begin
            iq[i] = v.ia[i];
            fq[i] = v.fa[i];
        end
        icnt = v.nops;
        fcnt = v.nops;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int nw, pops, busy_n, done_c, nw_exp;
        bit pair_bad, stall_bad, din_bad;
        logic [15:0] hold_din;
        nw = 0; pops = 0; busy_n = 0; done_c = -1;
        pair_bad = 0; stall_bad = 0; din_bad = 0; hold_din = '0;
        nw_exp = (v.len == 0 || v.num == 0) ? 0 : int'(v.num);
        load(v);
        @(posedge clk) #1;
        start = 1'b1;
        filt_len = v.len;
        num_out = v.num;
        #1 chk($sformatf("v%0d busy_c0", id), busy, 0);
        for (int c = 1; c <= 80 && done_c < 0; c++) begin
            @(posedge clk) #1;
            if (v.hold) begin
                filt_len = '0;
                num_out = '0;
            end else start = 1'b0;
            stall_e = c >= v.es && c <= v.ee;
            psum_full = c >= v.fs && c <= v.fe;
            #1;
            if (ifmap_ren !== filt_ren) pair_bad = 1;
            if (stall_e && ifmap_ren) stall_bad = 1;
            if (ifmap_ren) pops++;
            if (busy) busy_n++;
            if (c == v.fs) hold_din = psum_din;
            if (c > v.fs && c <= v.fe && psum_din !== hold_din) din_bad = 1;
            if (psum_wen) begin
                if (nw < 3) begin
                    chk($sformatf("v%0d psum%0d", id, nw), psum_din, v.psum[nw]);
                    chk($sformatf("v%0d wen_cyc%0d", id, nw), c, v.wcyc[nw]);
                end
                nw++;
            end
            if (done) done_c = c;
        end
        start = 1'b0;
        stall_e = 1'b0;
        psum_full = 1'b0;
        chk($sformatf("v%0d done_cyc", id), done_c, v.done_c);
        chk($sformatf("v%0d wen_count", id), nw, nw_exp);
        chk($sformatf("v%0d pops", id), pops, int'(v.len) * nw_exp);
        chk($sformatf("v%0d busy_cycles", id), busy_n, v.done_c);
        chk($sformatf("v%0d ren_pair", id), pair_bad, 0);
        if (v.es != 0) chk($sformatf("v%0d stall_ren", id), stall_bad, 0);
        if (v.fs != 0) chk($sformatf("v%0d full_din_stable", id), din_bad, 0);
        repeat (2) @(posedge clk);
        #1 chk($sformatf("v%0d idle_after", id), busy, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            vt[i] = '{len: 0, num: 0, nops: 0, ia: '0, fa: '0, psum: '0, wcyc: '0,
                      done_c: 0, es: 0, ee: 0, fs: 0, fe: 0, hold: 0};
        end
        vt[0].len = 3; vt[0].num = 1; vt[0].nops = 3;
        vt[0].ia = {8'd3, 8'd2, 8'd1}; vt[0].fa = {8'd6, 8'd5, 8'd4};
        vt[0].psum = 16'd32; vt[0].wcyc = 8'd5; vt[0].done_c = 6;
        vt[1].len = 2; vt[1].num = 1; vt[1].nops = 2;
        vt[1].ia = {8'd7, 8'hFD}; vt[1].fa = {8'hFE, 8'd5};
        vt[1].psum = 16'hFFE3; vt[1].wcyc = 8'd4; vt[1].done_c = 5;
        vt[2].len = 4; vt[2].num = 1; vt[2].nops = 4;
        vt[2].ia = {4{8'd127}}; vt[2].fa = {4{8'd127}};
`ifdef PE_MAC_SATURATE_EN
        vt[2].psum = 16'h7FFF;
`else
        vt[2].psum = 16'hFC04;
`endif
        vt[2].wcyc = 8'd6; vt[2].done_c = 7;
        vt[3].len = 2; vt[3].num = 2; vt[3].nops = 4;
        vt[3].ia = {8'd2, 8'd2, 8'd1, 8'd1}; vt[3].fa = {8'd4, 8'd4, 8'd3, 8'd3};
        vt[3].psum = {16'd16, 16'd6}; vt[3].wcyc = {8'd8, 8'd4}; vt[3].done_c = 9;
        vt[4] = vt[0];
        vt[4].es = 2; vt[4].ee = 5; vt[4].fs = 9; vt[4].fe = 11;
        vt[4].wcyc = 8'd12; vt[4].done_c = 13;
        vt[5].len = 0; vt[5].num = 1; vt[5].nops = 2;
        vt[5].ia = {8'd9, 8'd9}; vt[5].fa = {8'd9, 8'd9}; vt[5].done_c = 1;
        vt[6].len = 2; vt[6].num = 0; vt[6].nops = 2;
        vt[6].ia = {8'd9, 8'd9}; vt[6].fa = {8'd9, 8'd9}; vt[6].done_c = 1;
        vt[7].len = 1; vt[7].num = 3; vt[7].nops = 3;
        vt[7].ia = {8'd127, 8'h80, 8'h80}; vt[7].fa = {8'd1, 8'h80, 8'd127};
        vt[7].psum = {16'h007F, 16'h4000, 16'hC080}; vt[7].wcyc = {8'd9, 8'd6, 8'd3};
        vt[7].done_c = 10;

        #1 chk("reset_outputs", {busy, done, ifmap_ren, filt_ren, psum_wen, psum_din}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // start held high while busy with zeroed config must not restart or reconfigure the job
        vt[0].len = 2; vt[0].nops = 2;
        vt[0].ia = {8'd3, 8'd2}; vt[0].fa = {8'hFF, 8'd5};
        vt[0].psum = 16'd7; vt[0].wcyc = 8'd4; vt[0].done_c = 5; vt[0].hold = 1;
        run_vec(8, vt[0]);

        // reset in cycle 2 of an L=4 job aborts it with no write or done
        load(vt[2]);
        @(posedge clk) #1;
        start = 1'b1; filt_len = 4; num_out = 1;
        @(posedge clk) #1;
        start = 1'b0;
        @(posedge clk) #1;
        rst = 1'b1;
        #1 chk("rst_outputs", {busy, done, ifmap_ren, filt_ren, psum_wen, psum_din}, 0);
        @(posedge clk) #1;
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk) #1;
            if (psum_wen || done || ifmap_ren || busy) n++;
        end
        chk("rst_abort_quiet", n, 0);

        vt[0].len = 3; vt[0].nops = 3; vt[0].hold = 0;
        vt[0].ia = {8'd3, 8'd2, 8'd1}; vt[0].fa = {8'd6, 8'd5, 8'd4};
        vt[0].psum = 16'd32; vt[0].wcyc = 8'd5; vt[0].done_c = 6;
        run_vec(9, vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
